// File: rtl/gf180mcu_oai211_bist_pkg.sv
// rtl/gf180mcu_oai211_bist_pkg.sv - shared types and golden function for the oai211 BIST
package gf180mcu_oai211_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam int NUM_VEC = 16;

    function automatic logic oai211_expect(input logic [3:0] vec);
        return ~((vec[3] | vec[2]) & vec[1] & vec[0]);
    endfunction

endpackage

// File: rtl/gf180mcu_oai211_bist_settle.sv
// rtl/gf180mcu_oai211_bist_settle.sv - settle-time down-counter with load/expire handshake
module gf180mcu_oai211_bist_settle #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expire
);

    // Width floors at 1 so the counter still elaborates when settling is disabled.
    localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(SETTLE_CYCLES);
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Expiring on the last count makes SETTLE exactly SETTLE_CYCLES long.
    assign expire = (cnt <= CW'(1));

endmodule

// File: rtl/gf180mcu_oai211_bist.sv
// rtl/gf180mcu_oai211_bist.sv - exhaustive 16-vector self-test sequencer for the oai211 cell
module gf180mcu_oai211_bist
    import gf180mcu_oai211_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ZN,
    output logic             A1,
    output logic             A2,
    output logic             B,
    output logic             C,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [3:0]       FAIL_VEC
);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       vec;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       fail_vec;
    logic             settle_expire;
    logic             kick;
    logic             mismatch;
    logic             active;

    assign kick     = START && ((state == S_IDLE) || (state == S_DONE));
    // Case inequality so an undriven or floating ZN is reported as a failure.
    assign mismatch = (ZN !== oai211_expect(vec));
    assign active   = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_SAMPLE);

    gf180mcu_oai211_bist_settle #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk   (CLK),
        .rst   (RST),
        .load  (state == S_DRIVE),
        .run   (state == S_SETTLE),
        .expire(settle_expire)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (START) state_nxt = S_DRIVE;
            end
            S_DRIVE:  state_nxt = (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
            S_SETTLE: begin
                if (settle_expire) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: state_nxt = (vec == 4'(NUM_VEC - 1)) ? S_DONE : S_DRIVE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            vec      <= '0;
            err_cnt  <= '0;
            fail_vec <= '0;
        end else begin
            state <= state_nxt;
            if (kick) begin
                vec      <= '0;
                err_cnt  <= '0;
                fail_vec <= '0;
            end else if (state == S_SAMPLE) begin
                if (mismatch) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                    if (err_cnt == '0) fail_vec <= vec;
                end
                if (vec != 4'(NUM_VEC - 1)) vec <= vec + 4'd1;
            end
        end
    end

    assign {A1, A2, B, C} = active ? vec : 4'b0000;
    assign BUSY     = active;
    assign DONE     = (state == S_DONE);
    assign PASS     = (state == S_DONE) && (err_cnt == '0);
    assign ERR_CNT  = err_cnt;
    assign FAIL_VEC = fail_vec;

endmodule

// File: tb/tb_gf180mcu_oai211_bist.sv
// tb/tb_gf180mcu_oai211_bist.sv - self-checking bench for gf180mcu_oai211_bist
module tb_gf180mcu_oai211_bist;

    localparam int P = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] gold = 16'h777F;
    int          mode0 = 0;
    logic [15:0] mask0 = 16'h0000;

    logic a1_0, a2_0, b_0, c_0, busy0, done0, pass0, zn0;
    logic [4:0] err0;
    logic [3:0] fv0;
    logic a1_1, a2_1, b_1, c_1, busy1, done1, pass1, zn1;
    logic [4:0] err1;
    logic [3:0] fv1;
    logic a1_2, a2_2, b_2, c_2, busy2, done2, pass2, zn2;
    logic [1:0] err2;
    logic [3:0] fv2;
    logic [3:0] v0, v1, v2;

    assign v0  = {a1_0, a2_0, b_0, c_0};
    assign v1  = {a1_1, a2_1, b_1, c_1};
    assign v2  = {a1_2, a2_2, b_2, c_2};
    assign zn0 = (mode0 == 1) ? 1'b1 : (mode0 == 2) ? 1'b0 : (gold[v0] ^ mask0[v0]);
    assign zn1 = ~gold[v1];
    assign zn2 = 1'b0;

    gf180mcu_oai211_bist #(.SETTLE_CYCLES(2), .ERR_W(5)) u0 (
        .CLK(clk), .RST(rst), .START(start0), .ZN(zn0),
        .A1(a1_0), .A2(a2_0), .B(b_0), .C(c_0),
        .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_CNT(err0), .FAIL_VEC(fv0)
    );

    gf180mcu_oai211_bist #(.SETTLE_CYCLES(0), .ERR_W(5)) u1 (
        .CLK(clk), .RST(rst), .START(start1), .ZN(zn1),
        .A1(a1_1), .A2(a2_1), .B(b_1), .C(c_1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1), .FAIL_VEC(fv1)
    );

    gf180mcu_oai211_bist #(.SETTLE_CYCLES(2), .ERR_W(2)) u2 (
        .CLK(clk), .RST(rst), .START(start2), .ZN(zn2),
        .A1(a1_2), .A2(a2_2), .B(b_2), .C(c_2),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_CNT(err2), .FAIL_VEC(fv2)
    );

    // Reference: a run is a count of edges since the start edge; vector and phase follow by division.
    bit          m_active = 1'b0;
    bit          m_done = 1'b0;
    int          m_k = 0;
    int          m_err = 0;
    logic [3:0]  m_fv = 4'h0;
    int          m_vv;
    logic        m_z;
    bit          chk_en = 1'b0;

    function automatic logic model_zn(input int vv);
        if (mode0 == 1) return 1'b1;
        if (mode0 == 2) return 1'b0;
        return gold[vv] ^ mask0[vv];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_k      = 0;
            m_err    = 0;
            m_fv     = 4'h0;
        end else if (!m_active && start0) begin
            m_active = 1'b1;
            m_done   = 1'b0;
            m_k      = 0;
            m_err    = 0;
            m_fv     = 4'h0;
        end else if (m_active) begin
            if (m_k % P == P - 1) begin
                m_vv = m_k / P;
                m_z  = model_zn(m_vv);
                if (m_z != gold[m_vv]) begin
                    if (m_err == 0) m_fv = 4'(m_vv);
                    if (m_err < 31) m_err++;
                end
            end
            m_k++;
            if (m_k == 16 * P) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    end

    logic [15:0] exp_vec, act_vec;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_vec = {(m_active ? 4'(m_k / P) : 4'h0), m_active, m_done,
                       (m_done && m_err == 0), 5'(m_err), m_fv};
            act_vec = {v0, busy0, done0, pass0, err0, fv0};
            checks++;
            if (act_vec !== exp_vec) begin
                failures++;
                $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act_vec, exp_vec);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic run0(input bit noisy, output int n);
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        n = 0;
        while (!done0 && n < 200) begin
            @(negedge clk);
            n++;
            if (noisy) start0 = (n < 60) ? 1'($urandom) : 1'b0;
        end
        start0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int  n;
    int  low;
    bit  saw_done;

    initial begin
        #1;
        chk("reset_outputs_u0", int'({v0, busy0, done0, pass0, err0, fv0}), 0);
        chk("reset_outputs_u1", int'({v1, busy1, done1, pass1, err1, fv1}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        mode0 = 0; mask0 = 16'h0000;
        run0(1'b0, n);
        chk("ideal_latency", n, 64);
        chk("ideal_pass", int'(pass0), 1);
        chk("ideal_err", int'(err0), 0);

        mode0 = 1;
        run0(1'b0, n);
        chk("stuck1_err", int'(err0), 3);
        chk("stuck1_fail_vec", int'(fv0), 7);
        chk("stuck1_pass", int'(pass0), 0);

        mode0 = 2;
        run0(1'b0, n);
        chk("stuck0_err", int'(err0), 13);
        chk("stuck0_fail_vec", int'(fv0), 0);

        mode0 = 0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        chk("restart_done_clr", int'(done0), 0);
        chk("restart_err_clr", int'(err0), 0);
        chk("restart_pass_clr", int'(pass0), 0);
        chk("restart_busy", int'(busy0), 1);
        n = 0;
        while (!done0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("restart_latency", n, 64);
        chk("restart_pass", int'(pass0), 1);

        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        n = 0;
        while (v0 != 4'd5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_vec5", int'(v0), 5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_immediate", int'({v0, busy0, done0, pass0, err0, fv0}), 0);
        @(negedge clk) rst = 1'b0;
        saw_done = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (done0) saw_done = 1'b1;
        end
        chk("no_done_after_rst", int'(saw_done), 0);
        run0(1'b0, n);
        chk("post_rst_latency", n, 64);
        chk("post_rst_pass", int'(pass0), 1);

        run0(1'b1, n);
        chk("noisy_start_latency", n, 64);

        for (int it = 0; it < 4; it++) begin
            mask0 = 16'($urandom);
            run0(1'b0, n);
            low = 0;
            for (int i = 15; i >= 0; i--) if (mask0[i]) low = i;
            chk("rand_latency", n, 64);
            chk("rand_err", int'(err0), $countones(mask0));
            chk("rand_fail_vec", int'(fv0), low);
        end

        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        n = 0;
        while (!done1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("nosettle_latency", n, 32);
        chk("allbad_err", int'(err1), 16);
        chk("allbad_fail_vec", int'(fv1), 0);
        chk("allbad_pass", int'(pass1), 0);

        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        n = 0;
        while (!done2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("narrow_latency", n, 64);
        chk("narrow_err_sat", int'(err2), 3);
        chk("narrow_fail_vec", int'(fv2), 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
